instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 2048, instruction memory capacity in words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 13, byte-address width (log2(RAM_DEPTH*4)).
REQ-004 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker.
REQ-005 clka  input  1  single clock; all logic on rising edge.
REQ-006 rsta  input  1  reset, synchronous, active-high.
REQ-007 i_start  input  1  one-cycle pulse; begins a program load.
REQ-008 i_rx_data  input  8  byte from the UART receiver.
REQ-009 i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-010 i_pc  input  ADDR_WIDTH  CPU fetch byte address.
REQ-011 o_addr  output  ADDR_WIDTH  byte address to the instruction RAM port.
REQ-012 o_din  output  RAM_WIDTH  write data to the instruction RAM.
REQ-013 o_we  output  1  write enable to the instruction RAM.
REQ-014 o_cpu_stall  output  1  holds the CPU pipeline while memory is not owned by the CPU.
REQ-015 o_done  output  1  load complete; the CPU owns the RAM port.
REQ-016 o_overflow  output  1  program exceeded RAM_DEPTH words.
REQ-017 o_word_count  output  ADDR_WIDTH-1  number of words written in the last or current load.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, WRITE and DONE.
REQ-019 IDLE -> LOAD on i_start; in LOAD and WRITE, i_start SHALL be ignored.
REQ-020 DONE -> LOAD on i_start; word count, load address, byte counter and o_overflow SHALL be cleared on that transition.
REQ-021 In LOAD and WRITE, each i_rx_valid SHALL shift one byte into a 32-bit assembly register, first byte = bits 31:24 (big-endian), and advance a 2-bit byte counter.
REQ-022 When the fourth byte is accepted, the next cycle SHALL be WRITE: o_we=1 for exactly one cycle, o_din = assembled word, o_addr = load address.
REQ-023 After WRITE, the load address SHALL increment by 4 and o_word_count by 1; the next state is LOAD, or DONE if the written word equals HALT_WORD.
REQ-024 HALT_WORD SHALL itself be written to memory before entering DONE.
REQ-025 A byte arriving during the WRITE cycle SHALL be accepted as byte 0 of the next word, so no byte is lost.
REQ-026 If a fourth byte completes while o_word_count == RAM_DEPTH, there SHALL be no write; o_overflow SHALL be set to 1 and the FSM SHALL enter DONE.
REQ-027 i_rx_valid in IDLE or DONE SHALL be ignored.
REQ-028 o_addr SHALL equal the load address in LOAD and WRITE, and i_pc in IDLE and DONE (combinational mux).
REQ-029 o_we SHALL be 0 in all states except WRITE.
REQ-030 o_cpu_stall SHALL be 1 in IDLE, LOAD and WRITE, and 0 only in DONE.
REQ-031 o_done SHALL be 1 only in DONE.

Reset
REQ-032 On rsta the FSM SHALL enter IDLE, with o_we=0, o_din=0, o_done=0, o_overflow=0, o_word_count=0, o_cpu_stall=1, and the load address and byte counter at 0.
REQ-033 rsta asserted mid-load SHALL abort the load immediately, with no further write; memory contents are unaffected.

Configuration
REQ-034 With LOADER_CHECKSUM_EN defined, the block SHALL add output o_checksum[RAM_WIDTH-1:0], the XOR of all words written in the current load. It SHALL be cleared on reset and on the start of each load, and valid when o_done=1.
REQ-035 Without LOADER_CHECKSUM_EN, the o_checksum port and its logic SHALL be absent.

Structure
REQ-036 The FSM state encoding, HALT_WORD default and byte-per-word constant (4) SHALL reside in shared package mips_loader_pkg.
REQ-037 The byte assembler (shift register plus 2-bit counter) SHALL be sub-module byte_to_word_packer; the FSM, address counter and port mux remain in the top module.

Verification
REQ-038 Reset, i_start, then bytes 20,08,00,05 then FF,FF,FF,FF -> WRITE at o_addr 0 data 32'h20080005, WRITE at o_addr 4 data 32'hFFFFFFFF, o_done=1, o_word_count=2.
REQ-039 In DONE drive i_pc=0x0010 -> o_addr=0x0010, o_we=0, o_cpu_stall=0; further i_rx_valid causes no write.
REQ-040 Byte strobed in the same cycle as WRITE -> it becomes byte 0 of the next word; the next word is assembled correctly.
REQ-041 RAM_DEPTH=4: 5 non-halt words sent -> 4 writes at addresses 0,4,8,12, the fifth is not written, o_overflow=1, o_done=1.
REQ-042 rsta pulsed after 2 bytes of a word -> IDLE, o_we stays 0, o_word_count=0; a new i_start load begins at address 0.
REQ-043 LOADER_CHECKSUM_EN defined, words 32'h0000FFFF and 32'hFFFFFFFF loaded -> o_checksum=32'hFFFF0000 at o_done.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding,
// default end-of-program marker and bytes per instruction word.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD    = 4;

endpackage

// File: rtl/byte_to_word_packer.sv
// Big-endian byte assembler: the first byte lands in bits 31:24 and the
// 2-bit counter flags the byte that completes a 32-bit word.
module byte_to_word_packer
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next shift-register contents and byte position.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (i_clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (i_byte_valid) begin
      word_d = {word_q[23:0], i_byte};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_word          = word_q;
  assign o_word_complete = i_byte_valid && !i_clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program received byte-wise over UART into the instruction RAM,
// stalling the CPU until the HALT_WORD marker has been written.
// Optional feature: define LOADER_CHECKSUM_EN to add o_checksum, the XOR of
// all words written in the current load.
module instr_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int                   RAM_WIDTH  = 32,
  parameter int                   RAM_DEPTH  = 2048,
  parameter int                   ADDR_WIDTH = 13,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD  = RAM_WIDTH'(HALT_WORD_DEFAULT)
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [RAM_WIDTH-1:0]  o_din,
  output logic                  o_we,
  output logic                  o_cpu_stall,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH-2:0] o_word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [RAM_WIDTH-1:0]  o_checksum
`endif
);

  localparam logic [ADDR_WIDTH-2:0] DEPTH_CNT = (ADDR_WIDTH-1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES_PER_WORD);

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic [ADDR_WIDTH-2:0] word_cnt_q, word_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  stall_q, stall_d;

  logic                  load_start;
  logic                  pack_valid;
  logic                  pack_complete;
  logic [31:0]           pack_word;
  logic [RAM_WIDTH-1:0]  word_w;

  // Bytes are only taken while a load is in progress; the WRITE cycle counts
  // so a byte arriving then becomes byte 0 of the following word.
  assign pack_valid = i_rx_valid && ((state_q == LOAD) || (state_q == WRITE));

  byte_to_word_packer u_packer (
    .clk             (clka),
    .rst             (rsta),
    .i_clear         (load_start),
    .i_byte_valid    (pack_valid),
    .i_byte          (i_rx_data),
    .o_word          (pack_word),
    .o_word_complete (pack_complete)
  );

  // The packer register still holds the completed word throughout WRITE.
  assign word_w = RAM_WIDTH'(pack_word);

  // Next-state, load address, word count and overflow.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    word_cnt_d  = word_cnt_q;
    ovf_d       = ovf_q;
    load_start  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d     = LOAD;
          load_addr_d = '0;
          word_cnt_d  = '0;
          ovf_d       = 1'b0;
          load_start  = 1'b1;
        end
      end
      LOAD: begin
        if (pack_complete) begin
          if (word_cnt_q == DEPTH_CNT) begin
            state_d = DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        load_addr_d = load_addr_q + ADDR_STEP;
        word_cnt_d  = word_cnt_q + (ADDR_WIDTH-1)'(1);
        state_d     = (word_w == HALT_WORD) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
    we_d    = (state_d == WRITE);
    done_d  = (state_d == DONE);
    stall_d = (state_d != DONE);
  end

  // FSM and registered outputs.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q     <= IDLE;
      load_addr_q <= '0;
      word_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      word_cnt_q  <= word_cnt_d;
      ovf_q       <= ovf_d;
      we_q        <= we_d;
      done_q      <= done_d;
      stall_q     <= stall_d;
    end
  end

  // RAM port: loader owns the address while loading, CPU otherwise.
  assign o_addr       = ((state_q == LOAD) || (state_q == WRITE)) ? load_addr_q : i_pc;
  assign o_din        = we_q ? word_w : '0;
  assign o_we         = we_q;
  assign o_cpu_stall  = stall_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = word_cnt_q;

`ifdef LOADER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] chk_q, chk_d;

  // Running XOR of written words, restarted with every load.
  always_comb begin
    chk_d = chk_q;
    if (load_start) begin
      chk_d = '0;
    end else if (state_q == WRITE) begin
      chk_d = chk_q ^ word_w;
    end
  end

  // Checksum register.
  always_ff @(posedge clka) begin
    if (rsta) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign o_checksum = chk_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        clka = 1'b0;
  logic        rsta;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [12:0] pc;

  logic [12:0] addr0;
  logic [31:0] din0;
  logic        we0, stall0, done0, ovf0;
  logic [11:0] wc0;

  logic [3:0]  addr1;
  logic [31:0] din1;
  logic        we1, stall1, done1, ovf1;
  logic [2:0]  wc1;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] chk0, chk1;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  instr_mem_loader u_dut0 (
    .clka         (clka),
    .rsta         (rsta),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_pc         (pc),
    .o_addr       (addr0),
    .o_din        (din0),
    .o_we         (we0),
    .o_cpu_stall  (stall0),
    .o_done       (done0),
    .o_overflow   (ovf0),
    .o_word_count (wc0)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_checksum   (chk0)
`endif
  );

  instr_mem_loader #(.RAM_DEPTH(4), .ADDR_WIDTH(4)) u_dut1 (
    .clka         (clka),
    .rsta         (rsta),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_pc         (pc[3:0]),
    .o_addr       (addr1),
    .o_din        (din1),
    .o_we         (we1),
    .o_cpu_stall  (stall1),
    .o_done       (done1),
    .o_overflow   (ovf1),
    .o_word_count (wc1)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_checksum   (chk1)
`endif
  );

  // Write scoreboards: every observed write must match the oldest expected one.
  always @(negedge clka) begin
    if (we0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL wr0_unexpected addr=%h data=%h", addr0, din0);
      end else begin
        e0 = q0.pop_front();
        if ({19'b0, addr0} !== e0.addr || din0 !== e0.data) begin
          errors++;
          $display("FAIL wr0 got addr=%h data=%h exp addr=%h data=%h", addr0, din0, e0.addr, e0.data);
        end
      end
    end
    if (we1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wr1_unexpected addr=%h data=%h", addr1, din1);
      end else begin
        e1 = q1.pop_front();
        if ({28'b0, addr1} !== e1.addr || din1 !== e1.data) begin
          errors++;
          $display("FAIL wr1 got addr=%h data=%h exp addr=%h data=%h", addr1, din1, e1.addr, e1.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clka); #1;
    rsta = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clka); #1 start = 1'b1;
    @(posedge clka); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clka); #1 rx_data = b; rx_valid = 1'b1;
    @(posedge clka); #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic push_both(input logic [31:0] a, input logic [31:0] d);
    q0.push_back('{addr: a, data: d});
    q1.push_back('{addr: a, data: d});
  endtask

  task automatic wait_done0(input string name);
    for (int i = 0; i < 40 && done0 !== 1'b1; i++) begin
      @(posedge clka); #1;
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout done=%b exp 1", name, done0);
    end
    repeat (2) @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    pc = 13'h0AC;
    do_reset();
    checks++; if (done0 !== 1'b0)   begin errors++; $display("FAIL rst_done got %b exp 0", done0); end
    checks++; if (stall0 !== 1'b1)  begin errors++; $display("FAIL rst_stall got %b exp 1", stall0); end
    checks++; if (we0 !== 1'b0)     begin errors++; $display("FAIL rst_we got %b exp 0", we0); end
    checks++; if (ovf0 !== 1'b0)    begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf0); end
    checks++; if (wc0 !== 12'd0)    begin errors++; $display("FAIL rst_wc got %0d exp 0", wc0); end
    checks++; if (din0 !== 32'h0)   begin errors++; $display("FAIL rst_din got %h exp 0", din0); end
    checks++; if (addr0 !== 13'h0AC) begin errors++; $display("FAIL rst_addr_pc got %h exp 0ac", addr0); end
  endtask

  task automatic test_basic_load();
    pc = 13'h0;
    push_both(32'h0, 32'h2008_0005);
    push_both(32'h4, 32'hFFFF_FFFF);
    pulse_start();
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    wait_done0("basic");
    checks++; if (wc0 !== 12'd2)   begin errors++; $display("FAIL basic_wc got %0d exp 2", wc0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL basic_stall got %b exp 0", stall0); end
    checks++; if (ovf0 !== 1'b0)   begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf0); end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL basic_pending got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
    pc = 13'h0010;
    #1;
    checks++; if (addr0 !== 13'h0010) begin errors++; $display("FAIL done_addr_pc got %h exp 0010", addr0); end
    checks++; if (we0 !== 1'b0)       begin errors++; $display("FAIL done_we got %b exp 0", we0); end
    send_word(32'h1234_5678);
    repeat (3) @(posedge clka);
    #1;
    checks++; if (wc0 !== 12'd2)  begin errors++; $display("FAIL done_rx_wc got %0d exp 2", wc0); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL done_rx_done got %b exp 1", done0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h1122_3344;
    words[1] = 32'hAABB_CCDD;
    words[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) push_both(32'(i * 4), words[i]);
    pulse_start();
    @(posedge clka); #1;
    for (int i = 0; i < 12; i++) begin
      rx_data  = words[i / 4][31 - 8 * (i % 4) -: 8];
      rx_valid = 1'b1;
      @(posedge clka); #1;
    end
    rx_valid = 1'b0;
    wait_done0("b2b");
    checks++; if (wc0 !== 12'd3) begin errors++; $display("FAIL b2b_wc got %0d exp 3", wc0); end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL b2b_pending got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    push_both(32'h0, 32'hDEAD_BEEF);
    push_both(32'h4, 32'hFFFF_FFFF);
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    pulse_start();
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(32'hFFFF_FFFF);
    wait_done0("start_ign");
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL start_ign_pending got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q0.push_back('{addr: 32'(i * 4), data: 32'h0100_0000 + 32'(i)});
      if (i < 4) q1.push_back('{addr: 32'(i * 4), data: 32'h0100_0000 + 32'(i)});
    end
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(32'h0100_0000 + 32'(i));
    for (int i = 0; i < 10 && done1 !== 1'b1; i++) begin
      @(posedge clka); #1;
    end
    repeat (2) @(posedge clka);
    #1;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL ovf_done got %b exp 1", done1); end
    checks++; if (ovf1 !== 1'b1)  begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf1); end
    checks++; if (wc1 !== 3'd4)   begin errors++; $display("FAIL ovf_wc got %0d exp 4", wc1); end
    checks++; if (ovf0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL big_no_ovf got ovf=%b done=%b exp 0/0", ovf0, done0);
    end
    checks++; if (wc0 !== 12'd5)  begin errors++; $display("FAIL big_wc got %0d exp 5", wc0); end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL ovf_pending got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    pulse_start();
    send_byte(8'h12);
    send_byte(8'h34);
    @(posedge clka); #1 rsta = 1'b1;
    @(posedge clka); #1 rsta = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    checks++; if (wc0 !== 12'd0)   begin errors++; $display("FAIL midrst_wc got %0d exp 0", wc0); end
    checks++; if (stall0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL midrst_state got stall=%b done=%b exp 1/0", stall0, done0);
    end
    push_both(32'h0, 32'hCAFE_F00D);
    push_both(32'h4, 32'hFFFF_FFFF);
    pulse_start();
    send_word(32'hCAFE_F00D);
    send_word(32'hFFFF_FFFF);
    wait_done0("midrst");
    checks++; if (wc0 !== 12'd2) begin errors++; $display("FAIL midrst_wc2 got %0d exp 2", wc0); end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL midrst_pending got %0d/%0d exp 0/0", q0.size(), q1.size());
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    checks++; if (chk0 !== 32'h0) begin errors++; $display("FAIL chk_rst got %h exp 0", chk0); end
    push_both(32'h0, 32'h0000_FFFF);
    push_both(32'h4, 32'hFFFF_FFFF);
    pulse_start();
    send_word(32'h0000_FFFF);
    send_word(32'hFFFF_FFFF);
    wait_done0("chk");
    checks++; if (chk0 !== 32'hFFFF_0000) begin errors++; $display("FAIL chk got %h exp ffff0000", chk0); end
    checks++; if (chk1 !== 32'hFFFF_0000) begin errors++; $display("FAIL chk1 got %h exp ffff0000", chk1); end
  endtask
`endif

  initial begin
    rsta = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = '0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_start_ignored();
    test_overflow();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
